// File: rtl/dual_port_mem_responder_if.sv
// dual_port_mem_responder_if: request/address/ready handshake of one responder port
// readM/writeM/address driven by the requester (master), ready by the responder (slave)
interface dual_port_mem_responder_if #(parameter int WORD_SIZE = 16);
  logic readM;
  logic writeM;
  logic [WORD_SIZE-1:0] address;
  logic ready;
  modport master(output readM, writeM, address, input ready);
  modport slave(input readM, writeM, address, output ready);
endinterface

// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: fixed-latency memory responder for instruction and data ports
// ports: clk/reset; i_port,d_port handshakes; i_data,d_data shared inout buses;
// load_en/load_addr/load_data backdoor write; i_acc_count,d_acc_count completed accesses
module dual_port_mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  dual_port_mem_responder_if.slave i_port,
  inout  wire  [WORD_SIZE-1:0] i_data,
  dual_port_mem_responder_if.slave d_port,
  inout  wire  [WORD_SIZE-1:0] d_data,
  input  logic load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic [WORD_SIZE-1:0] i_acc_count,
  output logic [WORD_SIZE-1:0] d_acc_count
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state [2];
  state_t state_nx [2];
  logic [1:0] req, req_wr, commit, op_wr;
  logic [1:0][ADDR_BITS-1:0] req_addr, addr;
  logic [1:0][WORD_SIZE-1:0] bus_in, wdata, rdata, acc;
  logic [1:0][CW-1:0] cnt;
  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];
  logic unused_addr_hi;
  assign unused_addr_hi = ^{i_port.address[WORD_SIZE-1:ADDR_BITS], d_port.address[WORD_SIZE-1:ADDR_BITS]};
  // index 0 is the instruction port, index 1 the data port
  always_comb begin
    req = {d_port.readM | d_port.writeM, i_port.readM | i_port.writeM};
    req_wr = {d_port.writeM, i_port.writeM};
    req_addr = {d_port.address[ADDR_BITS-1:0], i_port.address[ADDR_BITS-1:0]};
    bus_in = {d_data, i_data};
    for (int p = 0; p < 2; p++) begin
      commit[p] = state[p] == WAIT && req[p] && cnt[p] == '0;
      state_nx[p] = state[p] == IDLE ? (req[p] ? WAIT : IDLE)
                  : state[p] == WAIT ? (!req[p] ? IDLE : commit[p] ? DONE : WAIT)
                  : IDLE;
    end
  end
  always_ff @(posedge clk)
    for (int p = 0; p < 2; p++) state[p] <= reset ? IDLE : state_nx[p];
  always_ff @(posedge clk) begin
    if (reset) begin
      op_wr <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (state[p] == IDLE && req[p]) begin
          op_wr[p] <= req_wr[p];
          addr[p] <= req_addr[p];
          cnt[p] <= CW'(LATENCY - 1);
          if (req_wr[p]) wdata[p] <= bus_in[p];
        end else if (state[p] == WAIT && cnt[p] != '0) cnt[p] <= cnt[p] - CW'(1);
        if (commit[p]) begin
          if (!op_wr[p]) rdata[p] <= mem[addr[p]];
          acc[p] <= acc[p] + WORD_SIZE'(1);
        end
      end
    end
  end
  // later assignments win: d-port over i-port, backdoor load over both
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) if (commit[p] && op_wr[p]) mem[addr[p]] <= wdata[p];
    if (load_en) mem[load_addr] <= load_data;
  end
  assign i_port.ready = state[0] == DONE;
  assign d_port.ready = state[1] == DONE;
  assign i_data = state[0] == DONE && !op_wr[0] ? rdata[0] : 'z;
  assign d_data = state[1] == DONE && !op_wr[1] ? rdata[1] : 'z;
  assign i_acc_count = acc[0];
  assign d_acc_count = acc[1];
endmodule
